// File: rtl/cnn_mac_engine.sv
// cnn_mac_engine: local operand RAM plus a sequenced signed multiply-accumulate engine
//   clk, rst                     clock, asynchronous active-high reset
//   host_we/addr/wdata/rdata     host RAM port (writes and reads honoured only while idle)
//   start, base_a, base_b,       job launch and job descriptor, latched on start
//   dst_addr, len, shift, relu_en
//   busy, done                   job in progress, one-cycle completion pulse
//   result, sat                  last written value and its saturation flag
module cnn_mac_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int ACC_WIDTH   = 40,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_we,
    input  logic [ADDR_WIDTH-1:0]  host_addr,
    input  logic [DATA_WIDTH-1:0]  host_wdata,
    output logic [DATA_WIDTH-1:0]  host_rdata,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_a,
    input  logic [ADDR_WIDTH-1:0]  base_b,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [ADDR_WIDTH-1:0]  len,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   sat
);
    typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ba_q, bb_q, dst_q, len_q;
    logic [SHIFT_WIDTH-1:0] sh_q;
    logic relu_q;
    logic [ADDR_WIDTH:0] cnt;
    logic vld, issue, ram_we, pos_ovf, neg_ovf, out_sat;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b, ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata, out_v;
    logic signed [DATA_WIDTH-1:0] rd_a, rd_b;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] acc, shifted, v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (len == '0 ? WRITE : RUN) : IDLE;
            RUN:     state_nx = (cnt == {1'b0, len_q}) ? WRITE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Port A serves the host while idle and the engine otherwise.
    always_comb begin
        busy      = state != IDLE;
        issue     = state == RUN && cnt < {1'b0, len_q};
        addr_a    = state == IDLE ? host_addr : ba_q + cnt[ADDR_WIDTH-1:0];
        addr_b    = bb_q + cnt[ADDR_WIDTH-1:0];
        ram_we    = state == WRITE || (state == IDLE && host_we);
        ram_waddr = state == WRITE ? dst_q : host_addr;
        ram_wdata = state == WRITE ? out_v : host_wdata;
    end

    // Result path: arithmetic shift, optional ReLU, then clamp when the
    // bits above the result's sign bit are not a pure sign extension.
    always_comb begin
        prod    = rd_a * rd_b;
        shifted = acc >>> sh_q;
        v       = (relu_q && shifted[ACC_WIDTH-1]) ? '0 : shifted;
        pos_ovf = !v[ACC_WIDTH-1] && (|v[ACC_WIDTH-2:DATA_WIDTH-1]);
        neg_ovf = v[ACC_WIDTH-1] && !(&v[ACC_WIDTH-2:DATA_WIDTH-1]);
        out_sat = pos_ovf || neg_ovf;
        out_v   = pos_ovf ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                  neg_ovf ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : v[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rd_a <= mem[addr_a];
        rd_b <= mem[addr_b];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ba_q       <= '0;
            bb_q       <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            sh_q       <= '0;
            relu_q     <= 1'b0;
            cnt        <= '0;
            vld        <= 1'b0;
            acc        <= '0;
            done       <= 1'b0;
            result     <= '0;
            sat        <= 1'b0;
            host_rdata <= '0;
        end else begin
            done <= state == WRITE;
            vld  <= issue;
            if (state == IDLE) host_rdata <= mem[addr_a];
            if (state == IDLE && start) begin
                ba_q   <= base_a;
                bb_q   <= base_b;
                dst_q  <= dst_addr;
                len_q  <= len;
                sh_q   <= shift;
                relu_q <= relu_en;
                cnt    <= '0;
                acc    <= '0;
            end
            if (issue) cnt <= cnt + 1'b1;
            // Data read at the issue edge lands one edge later.
            if (vld) acc <= acc + ACC_WIDTH'(prod);
            if (state == WRITE) begin
                result <= out_v;
                sat    <= out_sat;
            end
        end
    end
endmodule

// File: tb/tb_cnn_mac_engine.sv
// tb_cnn_mac_engine: directed self-checking bench for cnn_mac_engine
module tb_cnn_mac_engine;
    logic clk = 1'b0, rst = 1'b1;
    logic host_we = 1'b0;
    logic [11:0] host_addr = '0, base_a = '0, base_b = '0, dst_addr = '0, len = '0;
    logic [15:0] host_wdata = '0, host_rdata, result;
    logic start = 1'b0, relu_en = 1'b0, busy, done, sat;
    logic [4:0] shift = '0;
    int n_checks = 0, n_fail = 0;
    int edges, n_done;
    logic [15:0] rd;

    always #5 clk = ~clk;

    cnn_mac_engine dut (
        .clk(clk), .rst(rst), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .start(start),
        .base_a(base_a), .base_b(base_b), .dst_addr(dst_addr), .len(len),
        .shift(shift), .relu_en(relu_en), .busy(busy), .done(done),
        .result(result), .sat(sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [11:0] a, output logic [15:0] d);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        d = host_rdata;
    endtask

    task automatic run_job(input logic [11:0] ba, input logic [11:0] bb, input logic [11:0] dst,
                           input logic [11:0] n, input logic [4:0] sh, input logic re, output int e);
        @(negedge clk);
        start = 1'b1; base_a = ba; base_b = bb; dst_addr = dst; len = n; shift = sh; relu_en = re;
        @(posedge clk);
        #1 start = 1'b0;
        e = 0;
        while (e < 5000) begin
            @(posedge clk);
            e++;
            #1;
            if (done) break;
        end
        if (!done) check("job_timeout", 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_sat", sat, 0);
        check("rst_rdata", host_rdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) host_write(12'(i), 16'(i + 1));
        for (int i = 0; i < 4; i++) host_write(12'(100 + i), 16'(i + 5));
        run_job(0, 100, 200, 4, 0, 0, edges);
        check("dot_latency", edges, 6);
        check("dot_result", result, 70);
        check("dot_sat", sat, 0);
        check("dot_busy", busy, 0);
        @(posedge clk);
        #1 check("done_pulse_width", done, 0);
        host_read(200, rd);
        check("dot_ram", rd, 70);

        run_job(0, 100, 201, 4, 2, 0, edges);
        check("shift_result", result, 17);

        for (int i = 0; i < 4; i++) host_write(12'(i), 16'(-(i + 1)));
        run_job(0, 100, 202, 4, 0, 0, edges);
        check("neg_result", result, 16'hFFBA);
        run_job(0, 100, 203, 4, 0, 1, edges);
        check("relu_result", result, 0);
        check("relu_sat", sat, 0);

        host_write(0, 16'h7FFF); host_write(1, 16'h7FFF);
        host_write(8, 16'h7FFF); host_write(9, 16'h7FFF);
        run_job(0, 8, 204, 2, 0, 0, edges);
        check("satp_result", result, 16'h7FFF);
        check("satp_sat", sat, 1);
        host_write(8, 16'h8000); host_write(9, 16'h8000);
        run_job(0, 8, 205, 2, 0, 0, edges);
        check("satn_result", result, 16'h8000);
        check("satn_sat", sat, 1);

        host_write(5, 16'h1234);
        run_job(0, 0, 5, 0, 0, 0, edges);
        check("len0_latency", edges, 1);
        check("len0_sat", sat, 0);
        host_read(5, rd);
        check("len0_ram", rd, 0);

        host_write(12'hFFE, 1); host_write(12'hFFF, 2); host_write(0, 3); host_write(1, 4);
        for (int i = 0; i < 4; i++) host_write(12'(300 + i), 16'(10 * (i + 1)));
        run_job(12'hFFE, 300, 210, 4, 0, 0, edges);
        check("wrap_result", result, 300);

        // Start and host write issued mid-job must be dropped.
        host_write(212, 16'h0055);
        @(negedge clk);
        start = 1'b1; base_a = 12'hFFE; base_b = 300; dst_addr = 211; len = 4; shift = 0; relu_en = 0;
        @(negedge clk);
        start = 1'b1; dst_addr = 212; len = 0;
        host_we = 1'b1; host_addr = 300; host_wdata = 999;
        @(negedge clk);
        start = 1'b0; host_we = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("hs_done_count", n_done, 1);
        check("hs_result", result, 300);
        host_read(300, rd);
        check("hs_src_kept", rd, 10);
        host_read(212, rd);
        check("hs_dst_kept", rd, 16'h0055);
        host_read(211, rd);
        check("hs_ram", rd, 300);

        run_job(12'hFFE, 300, 220, 4, 0, 0, edges);
        check("b2b_first", result, 300);
        run_job(220, 12'hFFE, 221, 1, 0, 0, edges);
        check("b2b_latency", edges, 3);
        check("b2b_second", result, 300);

        host_write(230, 16'h0AAA);
        @(negedge clk);
        start = 1'b1; base_a = 0; base_b = 100; dst_addr = 230; len = 8; shift = 0; relu_en = 0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);
        host_read(230, rd);
        check("mid_rst_ram", rd, 16'h0AAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
